bscan_spi_bridge: RTL and testbench

BSCAN_SPI_BRIDGE -- requirements
Module: bscan_spi_bridge

---
 rtl/bscan_spi_bridge.sv | 160 ++++++++++++++++
 tb/tb_bscan_spi_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bscan_spi_bridge.sv
// JTAG user-DR to SPI bridge: a serial header selects an SPI transfer into a
// bit-wide readback buffer or a readback of that buffer over TDO.
// Optional feature: define BSCAN_SPI_LOOPBACK_EN to enable op=3 (LOOP),
// which stores TDI in the buffer instead of MISO and leaves CSB idle.
module bscan_spi_bridge #(
  parameter int unsigned N_CS   = 1,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned ADDR_W = 14,
  parameter logic [15:0] MAGIC  = 16'h59A6
) (
  input  logic            DRCK1,
  input  logic            RESET,
  input  logic            SEL,
  input  logic            SHIFT,
  input  logic            CAPTURE,
  input  logic            TDI,
  output logic            TDO,
  output logic            MOSI,
  input  logic            MISO,
  output logic [N_CS-1:0] CSB,
  output logic            busy,
  output logic            ovf
);

  localparam int unsigned HDR_W  = 24 + LEN_W;
  localparam int unsigned HCNT_W = $clog2(HDR_W);
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_READ, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [HDR_W-2:0]    r_hdr;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [LEN_W-1:0]    r_len, r_cnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_loop;
  logic [DEPTH-1:0]    r_buf;

  logic                w_abort, w_hdr_last, w_last, w_wr_ok, w_pref;
  logic                w_magic_ok, w_len_ok, w_cs_ok;
  logic                w_go_xfer, w_go_loop, w_go_read;
  logic [HDR_W-1:0]    w_hdr;
  logic [3:0]          w_op, w_cs;
  logic [LEN_W-1:0]    w_len, w_nxt_idx;
  logic [N_CS-1:0]     w_cs_mask;

  assign MOSI = TDI;

  // Header assembly and decode; the incoming bit completes the header.
  assign w_abort    = CAPTURE | ~SEL;
  assign w_hdr      = {TDI, r_hdr};
  assign w_hdr_last = (r_hcnt == HCNT_W'(HDR_W - 1));
  assign w_op       = w_hdr[19:16];
  assign w_cs       = w_hdr[23:20];
  assign w_len      = w_hdr[HDR_W-1:24];
  assign w_magic_ok = (w_hdr[15:0] == MAGIC);
  assign w_len_ok   = |w_len;
  assign w_cs_ok    = (32'(w_cs) < N_CS);
  assign w_cs_mask  = ~(N_CS'(1) << w_cs);
  assign w_go_xfer  = w_magic_ok & w_len_ok & w_cs_ok & (w_op == 4'd1);
  assign w_go_read  = w_magic_ok & w_len_ok & (w_op == 4'd2);
`ifdef BSCAN_SPI_LOOPBACK_EN
  assign w_go_loop  = w_magic_ok & w_len_ok & w_cs_ok & (w_op == 4'd3);
`else
  assign w_go_loop  = 1'b0;
`endif

  // Payload bit bookkeeping and readback prefetch of the next position.
  assign w_last    = (r_cnt == r_len - LEN_W'(1));
  assign w_wr_ok   = (32'(r_cnt) < DEPTH);
  assign w_nxt_idx = r_cnt + LEN_W'(1);
  assign w_pref    = (32'(w_nxt_idx) < 32'(r_wcnt)) ? r_buf[ADDR_W'(w_nxt_idx)] : 1'b0;

  // Next-state logic; abort wins over everything, SHIFT low is a pause.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else if (SHIFT) begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_last) begin
            if (w_go_xfer | w_go_loop) w_state_nxt = S_XFER;
            else if (w_go_read)        w_state_nxt = S_READ;
            else                       w_state_nxt = S_DONE;
          end
        end
        S_XFER, S_READ: begin
          if (w_last) w_state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge DRCK1) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_hdr   <= '0;
      r_hcnt  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_loop  <= 1'b0;
      CSB     <= '1;
      TDO     <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_XFER) || (w_state_nxt == S_READ);
      if (w_abort) begin
        r_hcnt <= '0;
        CSB    <= '1;
        TDO    <= 1'b0;
      end else if (SHIFT) begin
        case (r_state)
          S_IDLE: begin
            r_hdr <= w_hdr[HDR_W-1:1];
            if (w_hdr_last) begin
              r_hcnt <= '0;
              r_len  <= w_len;
              r_cnt  <= '0;
              if (w_go_xfer | w_go_loop) begin
                ovf    <= 1'b0;
                r_wcnt <= '0;
                r_loop <= w_go_loop;
                if (!w_go_loop) CSB <= w_cs_mask;
              end else if (w_go_read) begin
                TDO <= (r_wcnt != '0) & r_buf[0];
              end
            end else begin
              r_hcnt <= r_hcnt + HCNT_W'(1);
            end
          end
          S_XFER: begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_wr_ok) r_wcnt <= r_wcnt + WCNT_W'(1);
            else         ovf    <= 1'b1;
            if (w_last)  CSB    <= '1;
          end
          S_READ: begin
            r_cnt <= r_cnt + LEN_W'(1);
            TDO   <= w_last ? 1'b0 : w_pref;
          end
          default: ;
        endcase
      end
    end
  end

  // Readback buffer; contents are not reset.
  always_ff @(posedge DRCK1) begin
    if (!RESET && !w_abort && SHIFT && (r_state == S_XFER) && w_wr_ok)
      r_buf[ADDR_W'(r_cnt)] <= r_loop ? TDI : MISO;
  end

endmodule

// File: tb/tb_bscan_spi_bridge.sv
// Directed bench for bscan_spi_bridge (N_CS=2, ADDR_W=4 so overflow is reachable).
module tb_bscan_spi_bridge;

  localparam int unsigned N_CS   = 2;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [15:0] MAGIC  = 16'h59A6;

  logic            DRCK1 = 1'b0;
  logic            RESET, SEL, SHIFT, CAPTURE, TDI, MISO;
  logic            TDO, MOSI, busy, ovf;
  logic [N_CS-1:0] CSB;

  int n_cmp = 0;
  int n_mis = 0;

  bscan_spi_bridge #(
    .N_CS(N_CS), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .MAGIC(MAGIC)
  ) dut (
    .DRCK1(DRCK1), .RESET(RESET), .SEL(SEL), .SHIFT(SHIFT), .CAPTURE(CAPTURE),
    .TDI(TDI), .TDO(TDO), .MOSI(MOSI), .MISO(MISO), .CSB(CSB),
    .busy(busy), .ovf(ovf)
  );

  always #5 DRCK1 = ~DRCK1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk_hdr(input logic [3:0] op, input logic [3:0] cs,
                                         input logic [15:0] len, input logic [15:0] magic);
    return {len, cs, op, magic};
  endfunction

  // One clock with the given control levels.
  task automatic tick(input logic sel, input logic shift, input logic cap);
    @(negedge DRCK1);
    SEL = sel; SHIFT = shift; CAPTURE = cap; TDI = 1'b0;
    @(posedge DRCK1);
    #1;
  endtask

  // One shifted bit; outputs are sampled just before the consuming edge.
  task automatic shift_bit(input logic tdi, input logic miso, output logic tdo_pre,
                           output logic mosi_pre, output logic [N_CS-1:0] csb_pre);
    @(negedge DRCK1);
    SEL = 1'b1; SHIFT = 1'b1; CAPTURE = 1'b0; TDI = tdi; MISO = miso;
    #1;
    tdo_pre = TDO; mosi_pre = MOSI; csb_pre = CSB;
    @(posedge DRCK1);
    #1;
  endtask

  task automatic send_hdr(input logic [39:0] h);
    logic t, m;
    logic [N_CS-1:0] c;
    for (int i = 0; i < 40; i++) shift_bit(h[i], 1'b0, t, m, c);
  endtask

  // Shift n payload bits; collect TDO, count CSB[0]-low edges and MOSI errors.
  task automatic run_bits(input logic [31:0] tdi_v, input logic [31:0] miso_v, input int n,
                          output logic [31:0] tdo_v, output int low_cnt, output int mosi_err);
    logic t, m;
    logic [N_CS-1:0] c;
    tdo_v = '0; low_cnt = 0; mosi_err = 0;
    for (int i = 0; i < n; i++) begin
      shift_bit(tdi_v[i], miso_v[i], t, m, c);
      tdo_v[i] = t;
      if (c[0] == 1'b0) low_cnt++;
      if (m !== tdi_v[i]) mosi_err++;
    end
  endtask

  logic [31:0] rd, v;
  int          lo, me;

  initial begin
    RESET = 1'b1; SEL = 1'b0; SHIFT = 1'b0; CAPTURE = 1'b0; TDI = 1'b0; MISO = 1'b0;
    repeat (2) @(posedge DRCK1);
    #1;
    chk("rst_csb", 32'(CSB), 32'h3);
    chk("rst_tdo", 32'(TDO), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    @(negedge DRCK1);
    RESET = 1'b0;

    // XFER cs=0 len=8, TDI=A5, MISO=3C.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, MAGIC));
    chk("x1_csb_on", 32'(CSB), 32'h2);
    chk("x1_busy", 32'(busy), 32'h1);
    run_bits(32'hA5, 32'h3C, 8, rd, lo, me);
    chk("x1_low_edges", 32'(lo), 32'd8);
    chk("x1_mosi", 32'(me), 32'd0);
    chk("x1_csb_off", 32'(CSB), 32'h3);
    chk("x1_busy_end", 32'(busy), 32'h0);
    chk("x1_tdo_zero", 32'(rd), 32'h0);

    // READ len=8 then len=16.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd2, 4'd0, 16'd8, MAGIC));
    chk("r1_csb", 32'(CSB), 32'h3);
    chk("r1_busy", 32'(busy), 32'h1);
    run_bits(32'h0, 32'h0, 8, rd, lo, me);
    chk("r1_data", rd, 32'h3C);
    chk("r1_tdo_after", 32'(TDO), 32'h0);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd2, 4'd0, 16'd16, MAGIC));
    run_bits(32'h0, 32'h0, 16, rd, lo, me);
    chk("r2_data16", rd, 32'h003C);

    // Bad magic and bad cs stay silent; CAPTURE recovers.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, 16'h1234));
    chk("bm_busy", 32'(busy), 32'h0);
    run_bits(32'hFF, 32'hFF, 8, rd, lo, me);
    chk("bm_no_cs", 32'(lo), 32'd0);
    chk("bm_csb", 32'(CSB), 32'h3);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd2, 16'd8, MAGIC));
    chk("bc_csb", 32'(CSB), 32'h3);
    chk("bc_busy", 32'(busy), 32'h0);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd1, 16'd8, MAGIC));
    chk("cs1_csb", 32'(CSB), 32'h1);

    // Abort after bit 3 of an XFER, then a fresh header with a pause.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, MAGIC));
    run_bits(32'h0, 32'h0, 4, rd, lo, me);
    chk("ab_csb_held", 32'(CSB), 32'h2);
    tick(1'b1, 1'b0, 1'b1);
    chk("ab_csb_off", 32'(CSB), 32'h3);
    chk("ab_busy", 32'(busy), 32'h0);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, MAGIC));
    chk("ab_new_csb", 32'(CSB), 32'h2);
    v = 32'h5A;
    run_bits(32'h0, v, 3, rd, lo, me);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("pz_csb", 32'(CSB), 32'h2);
    chk("pz_busy", 32'(busy), 32'h1);
    v = v >> 3;
    run_bits(32'h0, v, 5, rd, lo, me);
    chk("pz_csb_off", 32'(CSB), 32'h3);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd2, 4'd0, 16'd8, MAGIC));
    run_bits(32'h0, 32'h0, 8, rd, lo, me);
    chk("pz_data", rd, 32'h5A);

    // Overflow: len=20 into a 16-bit buffer.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd20, MAGIC));
    run_bits(32'h0, 32'hABCDE, 20, rd, lo, me);
    chk("of_ovf", 32'(ovf), 32'h1);
    tick(1'b1, 1'b0, 1'b1);
    chk("of_sticky", 32'(ovf), 32'h1);
    send_hdr(mk_hdr(4'd2, 4'd0, 16'd20, MAGIC));
    run_bits(32'h0, 32'h0, 20, rd, lo, me);
    chk("of_data", rd, 32'h0BCDE);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, MAGIC));
    chk("of_clear", 32'(ovf), 32'h0);
    run_bits(32'h0, 32'h96, 8, rd, lo, me);

    // LOOP op=3.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd3, 4'd0, 16'd16, MAGIC));
    chk("lp_csb", 32'(CSB), 32'h3);
`ifdef BSCAN_SPI_LOOPBACK_EN
    chk("lp_busy", 32'(busy), 32'h1);
`else
    chk("lp_busy", 32'(busy), 32'h0);
`endif
    run_bits(32'hBEEF, 32'h0, 16, rd, lo, me);
    chk("lp_no_cs", 32'(lo), 32'd0);
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd2, 4'd0, 16'd16, MAGIC));
    run_bits(32'h0, 32'h0, 16, rd, lo, me);
`ifdef BSCAN_SPI_LOOPBACK_EN
    chk("lp_data", rd, 32'hBEEF);
`else
    chk("lp_data", rd, 32'h0096);
`endif

    // RESET mid-XFER drops CSB on the same edge.
    tick(1'b1, 1'b0, 1'b1);
    send_hdr(mk_hdr(4'd1, 4'd0, 16'd8, MAGIC));
    run_bits(32'h0, 32'h0, 2, rd, lo, me);
    chk("rx_csb_on", 32'(CSB), 32'h2);
    @(negedge DRCK1);
    RESET = 1'b1;
    @(posedge DRCK1);
    #1;
    chk("rx_csb", 32'(CSB), 32'h3);
    chk("rx_busy", 32'(busy), 32'h0);
    chk("rx_ovf", 32'(ovf), 32'h0);
    @(negedge DRCK1);
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
